// File: rtl/booth_mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // One step of datapath control: load operands, add/subtract (optionally 2M), shift.
    typedef struct packed {
        logic load;
        logic add_sub;   // 1: subtract the selected multiple of M
        logic add_en;    // 1: apply the selected multiple of M to HQ
        logic add_2m;    // 1: use 2M instead of M
        logic shift;     // 1: perform the arithmetic right shift of {HQ,LQ,Q_1}
    } mult_control_t;

    // Width of the multiplier register LQ: N+1, padded to even for radix-4.
    function automatic int lq_width(input int n, input int radix);
        int w;
        w = n + 1;
        if (radix == 4) return w + (w % 2);
        return w;
    endfunction

    // Number of add/shift steps for one product.
    function automatic int iter_count(input int n, input int radix);
        if (radix == 4) return lq_width(n, radix) / 2;
        return n + 1;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/response bundle between a multiplier client and booth_mult_seq.
interface booth_mult_seq_if #(
    parameter int N = 8
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           ready;
    logic [2*N-1:0] Y;
    logic [1:0]     Q_LSB;

    modport master (
        output start, signed_mode, A, B,
        input  busy, ready, Y, Q_LSB
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, ready, Y, Q_LSB
    );
endinterface

// File: rtl/booth_mult_seq_recoder.sv
// Booth digit recoder: maps the low multiplier bits to add/sub/2M controls.
// load/shift are left clear; the sequencer owns them.
module booth_recoder
    import booth_pkg::*;
#(
    parameter int RADIX = 2
) (
    input  logic [2:0]    bits,   // {LQ[1], LQ[0], Q_1}
    output mult_control_t ctl
);
    logic unused_b2;
    assign unused_b2 = bits[2];

    // Decode the current Booth digit.
    always_comb begin
        ctl = '0;
        if (RADIX == 4) begin
            case (bits)
                3'b001, 3'b010: ctl.add_en = 1'b1;
                3'b011:         begin ctl.add_en = 1'b1; ctl.add_2m = 1'b1; end
                3'b100:         begin ctl.add_en = 1'b1; ctl.add_2m = 1'b1; ctl.add_sub = 1'b1; end
                3'b101, 3'b110: begin ctl.add_en = 1'b1; ctl.add_sub = 1'b1; end
                default:        ;
            endcase
        end else begin
            case (bits[1:0])
                2'b01:   ctl.add_en = 1'b1;
                2'b10:   begin ctl.add_en = 1'b1; ctl.add_sub = 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, radix-2 or radix-4, signed or unsigned per request.
// Accepts a request whenever idle; product appears ITER+1 edges after start is sampled.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int N     = 8,
    parameter int RADIX = 2
) (
    input  logic          clk,
    input  logic          rst,    // asynchronous, active low
    booth_mult_seq_if.slave bus
);
    localparam int LW   = lq_width(N, RADIX);
    localparam int HW   = LW + 1;              // one spare bit so +/-2M never overflows
    localparam int FW   = HW + LW + 1;         // {HQ, LQ, Q_1}
    localparam int ITER = iter_count(N, RADIX);
    localparam int SH   = (RADIX == 4) ? 2 : 1;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
            $error("booth_mult_seq: RADIX must be 2 or 4");
        end
        if (N < 2) begin : g_bad_width
            $error("booth_mult_seq: N must be >= 2");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [HW-1:0]   m_q;
    logic [HW-1:0]   hq_q;
    logic [LW-1:0]   lq_q;
    logic            q1_q;
    logic [2*N-1:0]  y_q;
    logic            ready_q;

    mult_control_t   rec_ctl, ctl;
    logic            done;
    logic            ext_a, ext_b;
    logic [HW-1:0]   m_sel, m_opnd, sum;
    logic signed [FW-1:0] full, shifted;

    booth_recoder #(.RADIX(RADIX)) u_rec (
        .bits ({lq_q[1], lq_q[0], q1_q}),
        .ctl  (rec_ctl)
    );

    // Operand extension bits: sign in signed mode, zero otherwise.
    assign ext_a = bus.signed_mode & bus.A[N-1];
    assign ext_b = bus.signed_mode & bus.B[N-1];

    // One add/sub step then arithmetic right shift of the whole accumulator.
    always_comb begin
        m_sel   = rec_ctl.add_2m ? {m_q[HW-2:0], 1'b0} : m_q;
        m_opnd  = rec_ctl.add_sub ? ~m_sel : m_sel;
        sum     = hq_q + (rec_ctl.add_en ? m_opnd : '0)
                       + {{(HW-1){1'b0}}, rec_ctl.add_en & rec_ctl.add_sub};
        full    = {sum, lq_q, q1_q};
        shifted = full >>> SH;
    end

    // Sequencer next-state and step controls.
    always_comb begin
        state_d     = state_q;
        ctl         = rec_ctl;
        ctl.load    = 1'b0;
        ctl.shift   = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                ctl.load = 1'b1;
                state_d  = CALC;
            end
            CALC: begin
                ctl.shift = 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers, iteration counter and product output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            m_q     <= '0;
            hq_q    <= '0;
            lq_q    <= '0;
            q1_q    <= 1'b0;
            y_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= done;
            if (done) y_q <= (2*N)'({hq_q, lq_q});
            if (ctl.load) begin
                m_q   <= {{(HW-N){ext_a}}, bus.A};
                lq_q  <= {{(LW-N){ext_b}}, bus.B};
                hq_q  <= '0;
                q1_q  <= 1'b0;
                cnt_q <= CW'(ITER);
            end else if (ctl.shift) begin
                hq_q  <= shifted[FW-1 -: HW];
                lq_q  <= shifted[LW:1];
                q1_q  <= shifted[0];
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.ready = ready_q;
    assign bus.Y     = y_q;
    assign bus.Q_LSB = {lq_q[0], q1_q};
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench: N=8 and N=4 multipliers in both radices, driven in lockstep pairs.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic       start8 = 0, sm8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       start4 = 0, sm4 = 0;
    logic [3:0] a4 = 0, b4 = 0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.N(8)) if8r2 ();
    booth_mult_seq_if #(.N(8)) if8r4 ();
    booth_mult_seq_if #(.N(4)) if4r2 ();
    booth_mult_seq_if #(.N(4)) if4r4 ();

    assign if8r2.start = start8; assign if8r2.signed_mode = sm8; assign if8r2.A = a8; assign if8r2.B = b8;
    assign if8r4.start = start8; assign if8r4.signed_mode = sm8; assign if8r4.A = a8; assign if8r4.B = b8;
    assign if4r2.start = start4; assign if4r2.signed_mode = sm4; assign if4r2.A = a4; assign if4r2.B = b4;
    assign if4r4.start = start4; assign if4r4.signed_mode = sm4; assign if4r4.A = a4; assign if4r4.B = b4;

    booth_mult_seq #(.N(8), .RADIX(2)) u_d8r2 (.clk(clk), .rst(rst), .bus(if8r2));
    booth_mult_seq #(.N(8), .RADIX(4)) u_d8r4 (.clk(clk), .rst(rst), .bus(if8r4));
    booth_mult_seq #(.N(4), .RADIX(2)) u_d4r2 (.clk(clk), .rst(rst), .bus(if4r2));
    booth_mult_seq #(.N(4), .RADIX(4)) u_d4r4 (.clk(clk), .rst(rst), .bus(if4r4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One N=8 op on both radices; operands are scrambled after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input string tag);
        int lat2, lat4, n2, n4;
        lat2 = -1; lat4 = -1; n2 = 0; n4 = 0;
        @(negedge clk); a8 = a; b8 = b; sm8 = sm; start8 = 1;
        @(posedge clk); #1;
        start8 = 0; a8 = ~a; b8 = ~b; sm8 = ~sm;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (if8r2.ready) begin n2++; lat2 = k; chk({tag, "_y_r2"}, 64'(if8r2.Y), 64'(exp)); end
            if (if8r4.ready) begin n4++; lat4 = k; chk({tag, "_y_r4"}, 64'(if8r4.Y), 64'(exp)); end
        end
        chk({tag, "_lat_r2"}, 64'(lat2), 64'd10);
        chk({tag, "_lat_r4"}, 64'(lat4), 64'd6);
        chk({tag, "_nrdy_r2"}, 64'(n2), 64'd1);
        chk({tag, "_nrdy_r4"}, 64'(n4), 64'd1);
        chk({tag, "_hold_r2"}, 64'(if8r2.Y), 64'(exp));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] exp, input string tag);
        int lat2, lat4, n2, n4;
        lat2 = -1; lat4 = -1; n2 = 0; n4 = 0;
        @(negedge clk); a4 = a; b4 = b; sm4 = sm; start4 = 1;
        @(posedge clk); #1;
        start4 = 0; a4 = ~a; b4 = ~b; sm4 = ~sm;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (if4r2.ready) begin n2++; lat2 = k; chk({tag, "_y_r2"}, 64'(if4r2.Y), 64'(exp)); end
            if (if4r4.ready) begin n4++; lat4 = k; chk({tag, "_y_r4"}, 64'(if4r4.Y), 64'(exp)); end
        end
        chk({tag, "_lat_r2"}, 64'(lat2), 64'd6);
        chk({tag, "_lat_r4"}, 64'(lat4), 64'd4);
        chk({tag, "_nrdy_r2"}, 64'(n2), 64'd1);
        chk({tag, "_nrdy_r4"}, 64'(n4), 64'd1);
    endtask

    initial begin
        int n2, n4, bad2, bad4, ych2, ych4, nr;
        logic [15:0] yp2, yp4;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk("rst_busy", 64'(if8r2.busy), 64'd0);
        chk("rst_ready", 64'(if8r4.ready), 64'd0);
        chk("rst_y", 64'(if8r2.Y), 64'd0);
        chk("rst_qlsb", 64'(if8r4.Q_LSB), 64'd0);

        // directed N=8 products
        run8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "m3x7");
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uffxff");
        run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "sffxff");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s80x7f");
        run8(8'h00, 8'h5A, 1'b1, 16'h0000, "zero");
        run8(8'h7F, 8'h7F, 1'b0, 16'h3F01, "u7fx7f");
        run8(8'h80, 8'h02, 1'b0, 16'h0100, "u80x02");

        // start held high: one ready per ITER+2 cycles, Y only moves on ready
        n2 = 0; n4 = 0; bad2 = 0; bad4 = 0; ych2 = 0; ych4 = 0;
        @(negedge clk); a8 = 8'd12; b8 = 8'd13; sm8 = 1; start8 = 1;
        @(posedge clk); #1;
        yp2 = if8r2.Y; yp4 = if8r4.Y;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if8r2.ready) begin n2++; if (k % 11 != 10) bad2++; end
            if (if8r4.ready) begin n4++; if (k % 7 != 6) bad4++; end
            if (!if8r2.ready && if8r2.Y !== yp2) ych2++;
            if (!if8r4.ready && if8r4.Y !== yp4) ych4++;
            yp2 = if8r2.Y; yp4 = if8r4.Y;
        end
        start8 = 0;
        chk("b2b_n_r2", 64'(n2), 64'd3);
        chk("b2b_n_r4", 64'(n4), 64'd5);
        chk("b2b_pos_r2", 64'(bad2), 64'd0);
        chk("b2b_pos_r4", 64'(bad4), 64'd0);
        chk("b2b_ystable_r2", 64'(ych2), 64'd0);
        chk("b2b_ystable_r4", 64'(ych4), 64'd0);
        chk("b2b_y_r2", 64'(if8r2.Y), 64'h009C);
        chk("b2b_y_r4", 64'(if8r4.Y), 64'h009C);
        repeat (15) @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk); a8 = 8'hFD; b8 = 8'h07; sm8 = 1; start8 = 1;
        @(posedge clk); #1; start8 = 0;
        repeat (4) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("abort_busy_r2", 64'(if8r2.busy), 64'd0);
        chk("abort_busy_r4", 64'(if8r4.busy), 64'd0);
        chk("abort_ready", 64'(if8r2.ready), 64'd0);
        chk("abort_y_r2", 64'(if8r2.Y), 64'd0);
        chk("abort_y_r4", 64'(if8r4.Y), 64'd0);
        chk("abort_qlsb_r2", 64'(if8r2.Q_LSB), 64'd0);
        chk("abort_qlsb_r4", 64'(if8r4.Q_LSB), 64'd0);
        @(negedge clk); rst = 1;
        nr = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (if8r2.ready || if8r4.ready || if8r2.busy || if8r4.busy) nr++;
        end
        chk("abort_no_ready", 64'(nr), 64'd0);
        run8(8'd5, 8'd6, 1'b1, 16'd30, "post_rst");

        // exhaustive N=4 against an integer model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    int ea, eb, p;
                    ea = (s == 1 && a >= 8) ? a - 16 : a;
                    eb = (s == 1 && b >= 8) ? b - 16 : b;
                    p  = ea * eb;
                    run4(4'(a), 4'(b), 1'(s), 8'(p), "exh4");
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
